tdm_eight_one_mux: RTL and testbench
====================================

// Module: tdm_eight_one_mux
// PURPOSE
//  Time-division 8:1 multiplexer: the transmit end of the 1:8 demux path.
//  Captures one frame of eight WIDTH-bit channels plus an enable mask.
//  Emits the enabled channels one beat per accepted cycle on Y, each tagged with its channel code on Sel.
//  A downstream OneEightMux uses I<=Y and Sel<=Sel to route each beat back to lane Y[Sel].
// PARAMETERS
//  WIDTH   1   bits per channel / per output beat
// PORTS
//  clk         in   1          rising-edge clock (single clock domain)
//  rst_n       in   1          asynchronous, active-low reset
//  D           in   8*WIDTH    frame data; channel k = D[k*WIDTH +: WIDTH]
//  En          in   8          channel enable mask; bit k enables channel k
//  in_valid    in   1          frame offered on D/En
//  in_ready    out  1          block can accept a frame
//  Y           out  WIDTH      current beat data (= captured channel Sel)
//  Sel         out  3          channel index of current beat
//  out_valid   out  1          Y/Sel hold a valid beat
//  out_ready   in   1          sink accepts beat this cycle
//  frame_last  out  1          current beat is last enabled channel of frame
//  frame_cnt   out  8          count of fully transmitted frames
// BEHAVIOUR
//  Reset (rst_n=0, async, any time):
//   - state=IDLE; frame/mask regs=0; Y=0, Sel=0, out_valid=0, frame_last=0, frame_cnt=0.
//   - in_ready=1 once reset is released.
//   - A frame in flight is abandoned; no further beats from it.
//  FSM, two states:
//   - IDLE: in_ready=1, out_valid=0.
//   - SEND: in_ready=0, out_valid=1.
//  IDLE, on in_valid&in_ready:
//   - Capture D and En.
//   - En==8'h00: frame is discarded; stay IDLE; frame_cnt unchanged.
//   - Otherwise: SEND next cycle with Sel = lowest set bit of En.
//     Y = channel Sel; frame_last = (no higher En bit set).
//  SEND:
//   - Y/Sel/frame_last are registered and held stable while out_ready=0 (no limit on stall length).
//   - On out_ready with frame_last=0: Sel advances to the next higher set En bit; disabled channels are skipped with no bubble.
//   - On out_ready with frame_last=1: go to IDLE next cycle; frame_cnt += 1, wrapping 8'hFF -> 8'h00.
//  Latency and throughput:
//   - Frame accepted at edge k -> first beat valid after edge k; one beat per cycle under out_ready=1.
//   - One IDLE cycle between consecutive frames.
//  Other rules:
//   - in_valid during SEND is ignored (in_ready=0); D/En changes do not affect the captured frame.
//   - Beat order is strictly ascending channel index; a frame yields popcount(En) beats.
//   - Sel is 3 bits; the index never wraps within a frame. Channel 7 is always last when enabled.
// TESTING
//  1. Reset: rst_n=0 -> out_valid=0, Y=0, Sel=0, frame_cnt=0.
//     Release -> in_ready=1.
//  2. WIDTH=1, D=8'b1010_0110, En=8'hFF, out_ready=1:
//     -> 8 beats, Sel=0..7, Y=0,1,1,0,0,1,0,1.
//     frame_last only on Sel=7; frame_cnt=1; in_ready=1 one cycle after.
//  3. En=8'b1000_0101, D=8'hFF:
//     -> 3 beats, Sel=0,2,7, all Y=1; frame_last on Sel=7.
//     En=8'h00 -> no beats, frame_cnt unchanged.
//  4. Backpressure: hold out_ready=0 for 5 cycles at Sel=2.
//     -> Y/Sel/frame_last constant; in_ready=0; D changes mid-frame do not alter later beats.
//  5. Reset mid-frame (rst_n=0 at Sel=3):
//     -> out_valid=0 immediately, Sel=0.
//     After release, new frame D=8'h01, En=8'h01 -> single beat Sel=0, Y=1, frame_last=1.
//  6. Loopback to OneEightMux, 256 frames:
//     -> demux outputs match each frame's D on enabled lanes; frame_cnt wraps to 0.

Source files
------------

// File: rtl/tdm_eight_one_mux.sv
// Time-division 8:1 multiplexer: captures a frame of eight channels plus an enable
// mask and emits the enabled channels as one tagged beat per accepted cycle.
module tdm_eight_one_mux #(
    parameter int WIDTH = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [8*WIDTH-1:0]   D,
    input  logic [7:0]           En,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     Y,
    output logic [2:0]           Sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_last,
    output logic [7:0]           frame_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Index of the lowest set bit; caller guarantees a non-zero mask.
    function automatic logic [2:0] lowest_idx(input logic [7:0] mask);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = mask[i] ? 3'(i) : idx;
        end
        return idx;
    endfunction

    function automatic logic [7:0] mask_above(input logic [7:0] mask, input logic [2:0] idx);
        logic [7:0] keep;
        for (int i = 0; i < 8; i++) begin
            keep[i] = (3'(i) > idx);
        end
        return mask & keep;
    endfunction

    function automatic logic [WIDTH-1:0] chan_data(input logic [8*WIDTH-1:0] data,
                                                   input logic [2:0]         idx);
        return data[int'(idx)*WIDTH +: WIDTH];
    endfunction

    state_t               state_r, state_s;
    logic [8*WIDTH-1:0]   data_r, data_s;
    logic [7:0]           mask_r, mask_s;
    logic [2:0]           sel_r, sel_s;
    logic [WIDTH-1:0]     y_r, y_s;
    logic                 last_r, last_s;
    logic [7:0]           cnt_r, cnt_s;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic [2:0]           first_s;
    logic [2:0]           nxt_s;
    logic [7:0]           rem_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-beat selection; skipping disabled lanes is a priority pick on the remaining mask.
    always_comb begin
        state_s = state_r;
        data_s  = data_r;
        mask_s  = mask_r;
        sel_s   = sel_r;
        y_s     = y_r;
        last_s  = last_r;
        cnt_s   = cnt_r;
        first_s = lowest_idx(En);
        rem_s   = mask_above(mask_r, sel_r);
        nxt_s   = lowest_idx(rem_s);
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    data_s = D;
                    mask_s = En;
                    if (En != 8'h00) begin
                        state_s = SEND;
                        sel_s   = first_s;
                        y_s     = chan_data(D, first_s);
                        last_s  = (mask_above(En, first_s) == 8'h00);
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (last_r) begin
                        state_s = IDLE;
                        cnt_s   = cnt_r + 8'd1;
                    end else begin
                        sel_s  = nxt_s;
                        y_s    = chan_data(data_r, nxt_s);
                        last_s = (mask_above(mask_r, nxt_s) == 8'h00);
                    end
                end else begin
                    state_s = SEND;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Frame capture, beat and handshake registers; in_ready resets high so it is asserted on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r      <= '0;
            mask_r      <= 8'h00;
            sel_r       <= 3'd0;
            y_r         <= '0;
            last_r      <= 1'b0;
            cnt_r       <= 8'h00;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            data_r      <= data_s;
            mask_r      <= mask_s;
            sel_r       <= sel_s;
            y_r         <= y_s;
            last_r      <= last_s;
            cnt_r       <= cnt_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == SEND);
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign Y          = y_r;
    assign Sel        = sel_r;
    assign frame_last = last_r;
    assign frame_cnt  = cnt_r;

endmodule

// File: tb/tb_tdm_eight_one_mux.sv
// Randomised bench for tdm_eight_one_mux against a queue-of-beats reference model
// with a behavioural 1:8 demux on the output side.
module tb_tdm_eight_one_mux;

    localparam int WIDTH = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   D;
    logic [7:0]   En;
    logic         in_valid;
    logic         in_ready;
    logic [0:0]   Y;
    logic [2:0]   Sel;
    logic         out_valid;
    logic         out_ready;
    logic         frame_last;
    logic [7:0]   frame_cnt;

    typedef struct {
        int sel;
        int y;
        int last;
    } beat_t;

    beat_t       m_q[$];
    bit          m_busy;
    logic [7:0]  m_cnt;
    logic [7:0]  m_d;
    logic [7:0]  m_en;
    logic [7:0]  lanes;
    int          total;
    int          bad;
    int          frames_done;

    always #5 clk = ~clk;

    tdm_eight_one_mux #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .D          (D),
        .En         (En),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Y          (Y),
        .Sel        (Sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_last (frame_last),
        .frame_cnt  (frame_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_val("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
        check_val("out_valid", {31'd0, out_valid}, {31'd0, m_busy});
        check_val("frame_cnt", {24'd0, frame_cnt}, {24'd0, m_cnt});
        if (m_busy) begin
            check_val("sel", {29'd0, Sel}, m_q[0].sel);
            check_val("y", {31'd0, Y}, m_q[0].y);
            check_val("frame_last", {31'd0, frame_last}, m_q[0].last);
        end
    endtask

    // Called at a falling edge: check, drive, advance the model over the next rising edge.
    task automatic cycle(input logic [7:0] d, input logic [7:0] en, input logic iv, input logic ordy);
        beat_t b;
        check_outputs();
        D         = d;
        En        = en;
        in_valid  = iv;
        out_ready = ordy;
        if (!m_busy) begin
            if (iv && en != 8'h00) begin
                m_q.delete();
                for (int k = 0; k < 8; k++) begin
                    if (en[k]) begin
                        b.sel  = k;
                        b.y    = int'(d[k]);
                        b.last = 0;
                        m_q.push_back(b);
                    end
                end
                m_q[m_q.size()-1].last = 1;
                m_busy = 1'b1;
                m_d    = d;
                m_en   = en;
                lanes  = 8'h00;
            end
        end else if (ordy) begin
            if (!$isunknown(Sel)) lanes[Sel] = Y[0];
            void'(m_q.pop_front());
            if (m_q.size() == 0) begin
                m_busy = 1'b0;
                m_cnt  = m_cnt + 8'd1;
                frames_done++;
                check_val("demux_lanes", {24'd0, lanes & m_en}, {24'd0, m_d & m_en});
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input logic ordy_always);
        int n;
        n = 0;
        while (m_busy && n < 200) begin
            cycle(8'($urandom), 8'($urandom), 1'b1, ordy_always ? 1'b1 : 1'($urandom_range(0, 1)));
            n++;
        end
        check_val("drain_timeout", {31'd0, m_busy}, 32'd0);
    endtask

    task automatic run_to_sel(input int s);
        int n;
        n = 0;
        while (!(m_busy && m_q[0].sel == s) && n < 50) begin
            cycle(8'($urandom), 8'($urandom), 1'b1, 1'b1);
            n++;
        end
        check_val("reach_sel_timeout", {31'd0, m_busy}, 32'd1);
    endtask

    task automatic do_reset_now();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_sel", {29'd0, Sel}, 32'd0);
        check_val("rst_y", {31'd0, Y}, 32'd0);
        check_val("rst_frame_last", {31'd0, frame_last}, 32'd0);
        check_val("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        m_q.delete();
        m_busy      = 1'b0;
        m_cnt       = 8'h00;
        frames_done = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("rel_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int guard;
        total = 0; bad = 0; frames_done = 0;
        m_busy = 1'b0; m_cnt = 8'h00; m_d = 8'h00; m_en = 8'h00; lanes = 8'h00;
        rst_n = 1'b0; D = 8'h00; En = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        do_reset_now();

        // Full frame, every channel enabled, no stalls.
        cycle(8'b1010_0110, 8'hFF, 1'b1, 1'b1);
        drain(1'b1);
        cycle(8'h00, 8'h00, 1'b0, 1'b1);

        // Sparse mask, then an empty mask that must be discarded.
        cycle(8'hFF, 8'b1000_0101, 1'b1, 1'b1);
        drain(1'b1);
        cycle(8'h5A, 8'h00, 1'b1, 1'b1);
        cycle(8'h00, 8'h00, 1'b0, 1'b1);
        cycle(8'h00, 8'h00, 1'b0, 1'b1);

        // Five-cycle stall at channel 2 with D churning underneath.
        cycle(8'hC5, 8'hFF, 1'b1, 1'b1);
        run_to_sel(2);
        repeat (5) cycle(8'($urandom), 8'($urandom), 1'b1, 1'b0);
        drain(1'b1);

        // Reset in the middle of a frame, then a single-beat frame.
        cycle(8'hFF, 8'hFF, 1'b1, 1'b1);
        run_to_sel(3);
        do_reset_now();
        cycle(8'h01, 8'h01, 1'b1, 1'b1);
        drain(1'b0);
        cycle(8'h00, 8'h00, 1'b0, 1'b1);

        // Random frames through the behavioural demux until frame_cnt wraps.
        guard = 0;
        while (frames_done < 260 && guard < 30000) begin
            cycle(8'($urandom),
                  ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom),
                  1'($urandom_range(0, 9) < 7),
                  1'($urandom_range(0, 3) != 0));
            guard++;
        end
        check_val("random_frames_timeout", {31'd0, 1'(frames_done >= 260)}, 32'd1);
        drain(1'b1);
        check_outputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
